fp_div_vector_sequencer: RTL and testbench

//  Drives the floating-point divider over a vector: reads N_ELEM numerators from a buffer, divides

---
 rtl/fp_div_vector_sequencer.sv | 133 +++++++++++++
 tb/tb_fp_div_vector_sequencer.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_vector_sequencer.sv
// fp_div_vector_sequencer
// Walks a numerator buffer, sends each element with one shared denominator
// to an external floating-point divider, and writes the quotients back.
// Exception flags from every divide in the current vector are ORed together.
// Only one divide is outstanding at a time, so the divider needs no tagging.
module fp_div_vector_sequencer #(
  parameter int EXP_WIDTH   = 8,
  parameter int MANT_WIDTH  = 24,
  parameter int TOTAL_WIDTH = EXP_WIDTH + MANT_WIDTH,
  parameter int N_ELEM      = 8,
  parameter int IDX_W       = ($clog2(N_ELEM) > 0) ? $clog2(N_ELEM) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [TOTAL_WIDTH-1:0] denom,
  input  logic [2:0]             round_mode,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
  output logic [4:0]             exc_acc,
  output logic                   num_rd_en,
  output logic [IDX_W-1:0]       num_rd_addr,
  input  logic [TOTAL_WIDTH-1:0] num_rd_data,
  output logic                   res_wr_en,
  output logic [IDX_W-1:0]       res_wr_addr,
  output logic [TOTAL_WIDTH-1:0] res_wr_data,
  output logic                   div_in_valid,
  output logic [TOTAL_WIDTH-1:0] div_a,
  output logic [TOTAL_WIDTH-1:0] div_b,
  output logic [2:0]             div_round_mode,
  output logic                   div_cancel,
  input  logic                   div_in_ready,
  input  logic                   div_out_valid,
  input  logic [TOTAL_WIDTH-1:0] div_out,
  input  logic [4:0]             div_exceptions
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_WRITE = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

  logic [2:0]             state;
  logic [IDX_W-1:0]       idx;
  logic [TOTAL_WIDTH-1:0] denom_q;
  logic [2:0]             round_mode_q;
  logic [TOTAL_WIDTH-1:0] quot_q;

  // Sequencer state, operand/result registers and the abort/cancel pulses.
  // Abort outranks every state transition except IDLE, where it only blocks start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      idx            <= '0;
      denom_q        <= '0;
      round_mode_q   <= '0;
      quot_q         <= '0;
      exc_acc        <= '0;
      div_a          <= '0;
      div_b          <= '0;
      div_round_mode <= '0;
      aborted        <= 1'b0;
      div_cancel     <= 1'b0;
    end else begin
      aborted    <= 1'b0;
      div_cancel <= 1'b0;
      if (abort && (state != S_IDLE)) begin
        state      <= S_IDLE;
        aborted    <= 1'b1;
        div_cancel <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              denom_q      <= denom;
              round_mode_q <= round_mode;
              idx          <= '0;
              exc_acc      <= '0;
              state        <= S_FETCH;
            end
          end
          S_FETCH: state <= S_LOAD;
          S_LOAD: begin
            div_a          <= num_rd_data;
            div_b          <= denom_q;
            div_round_mode <= round_mode_q;
            state          <= S_ISSUE;
          end
          S_ISSUE: begin
            if (div_in_ready) state <= S_WAIT;
          end
          S_WAIT: begin
            if (div_out_valid) begin
              quot_q  <= div_out;
              exc_acc <= exc_acc | div_exceptions;
              state   <= S_WRITE;
            end
          end
          S_WRITE: begin
            if (idx == LAST_IDX) begin
              state <= S_DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_FETCH;
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Strobes are pure state decodes; addresses always follow the element index.
  always_comb begin
    busy         = (state != S_IDLE);
    done         = (state == S_DONE);
    num_rd_en    = (state == S_FETCH);
    num_rd_addr  = idx;
    res_wr_en    = (state == S_WRITE);
    res_wr_addr  = idx;
    res_wr_data  = quot_q;
    div_in_valid = (state == S_ISSUE);
  end

endmodule

// File: tb/tb_fp_div_vector_sequencer.sv
// tb_fp_div_vector_sequencer
// Drives vectors through the sequencer with a behavioural divider and
// numerator buffer; a monitor checks every write/done/abort against a queue
// of expected events computed from the vector contents.
module tb_fp_div_vector_sequencer;

  localparam int N  = 3;
  localparam int TW = 32;
  localparam int IW = 2;

  localparam int K_WR   = 0;
  localparam int K_DONE = 1;
  localparam int K_ABT  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [TW-1:0] denom = '0;
  logic [2:0] round_mode = '0;
  logic busy, done, aborted;
  logic [4:0] exc_acc;
  logic num_rd_en;
  logic [IW-1:0] num_rd_addr;
  logic [TW-1:0] num_rd_data = '0;
  logic res_wr_en;
  logic [IW-1:0] res_wr_addr;
  logic [TW-1:0] res_wr_data;
  logic div_in_valid;
  logic [TW-1:0] div_a, div_b;
  logic [2:0] div_round_mode;
  logic div_cancel;
  logic div_in_ready = 1'b0;
  logic div_out_valid = 1'b0;
  logic [TW-1:0] div_out = '0;
  logic [4:0] div_exceptions = '0;

  int tests = 0;
  int failed = 0;

  typedef struct {
    int          kind;
    int          addr;
    logic [31:0] data;
    logic [4:0]  exc;
  } ev_t;
  ev_t exp_q[$];

  fp_div_vector_sequencer #(.EXP_WIDTH(8), .MANT_WIDTH(24), .N_ELEM(N)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .denom(denom),
    .round_mode(round_mode), .busy(busy), .done(done), .aborted(aborted),
    .exc_acc(exc_acc), .num_rd_en(num_rd_en), .num_rd_addr(num_rd_addr),
    .num_rd_data(num_rd_data), .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr),
    .res_wr_data(res_wr_data), .div_in_valid(div_in_valid), .div_a(div_a),
    .div_b(div_b), .div_round_mode(div_round_mode), .div_cancel(div_cancel),
    .div_in_ready(div_in_ready), .div_out_valid(div_out_valid), .div_out(div_out),
    .div_exceptions(div_exceptions)
  );

  always #5 clk = ~clk;

  // Reference divider: exact IEEE results for the known vectors, otherwise a
  // deterministic scramble of (a, b, rm) so wrong operands show up as wrong data.
  function automatic logic [31:0] ref_quot(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] rm);
    if (rm == 3'd0) begin
      if (b == 32'h40000000 && a == 32'h40C00000) return 32'h40400000;
      if (b == 32'h40000000 && a == 32'hC1400000) return 32'hC0C00000;
      if (b == 32'h40000000 && a == 32'h3F800000) return 32'h3F000000;
      if (b == 32'h40400000 && a == 32'h3F800000) return 32'h3EAAAAAB;
      if (b == 32'h40400000 && a == 32'h40C00000) return 32'h40000000;
      if (b == 32'h00000000 && a == 32'h40C00000) return 32'h7F800000;
    end
    return (a ^ {b[15:0], b[31:16]}) + {29'd0, rm} + 32'h13579BDF;
  endfunction

  function automatic logic [4:0] ref_exc(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] rm);
    if (rm == 3'd0) begin
      if (b == 32'h40400000 && a == 32'h3F800000) return 5'b00001;
      if (b == 32'h00000000 && a == 32'h40C00000) return 5'b01000;
      if (b == 32'h40000000 || b == 32'h40400000) return 5'b00000;
    end
    return a[4:0] ^ b[9:5] ^ {2'b00, rm};
  endfunction

  // Numerator buffer: one-cycle read latency.
  logic [31:0] num_mem [N];
  always @(posedge clk) begin
    if (num_rd_en) num_rd_data <= num_mem[num_rd_addr];
  end

  // Behavioural divider with random latency and random/forced-low in_ready.
  int lat_min = 1;
  int lat_max = 5;
  bit hold_ready = 1'b0;
  bit inject_spur = 1'b0;
  bit m_busy = 1'b0;
  int m_cnt = 0;
  logic [31:0] m_a, m_b;
  logic [2:0] m_rm;
  int xfer_count = 0;

  always @(posedge clk) begin
    div_out_valid <= 1'b0;
    if (rst || div_cancel) begin
      m_busy       <= 1'b0;
      div_in_ready <= 1'b0;
    end else if (m_busy) begin
      div_in_ready <= 1'b0;
      if (m_cnt == 0) begin
        div_out_valid  <= 1'b1;
        div_out        <= ref_quot(m_a, m_b, m_rm);
        div_exceptions <= ref_exc(m_a, m_b, m_rm);
        m_busy         <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (div_in_valid && div_in_ready) begin
      m_busy       <= 1'b1;
      m_a          <= div_a;
      m_b          <= div_b;
      m_rm         <= div_round_mode;
      m_cnt        <= $urandom_range(lat_max, lat_min);
      xfer_count   <= xfer_count + 1;
      div_in_ready <= 1'b0;
    end else begin
      div_in_ready <= !hold_ready && ($urandom_range(3, 0) != 0);
      if (inject_spur) begin
        div_out_valid  <= 1'b1;
        div_out        <= 32'hDEADBEEF;
        div_exceptions <= 5'h1F;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic handleEvent(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      tests++;
      failed++;
      $display("[TB] FAIL unexpected event: kind %0d addr %0d data %h", kind, res_wr_addr,
               res_wr_data);
    end else begin
      e = exp_q.pop_front();
      checkOutput("event kind", kind, e.kind);
      if (e.kind == K_WR && kind == K_WR) begin
        checkOutput("write addr", res_wr_addr, e.addr);
        checkOutput("write data", res_wr_data, e.data);
      end
      if (e.kind == K_DONE && kind == K_DONE) checkOutput("exc_acc at done", exc_acc, e.exc);
      if (e.kind == K_ABT && kind == K_ABT) checkOutput("div_cancel with aborted", div_cancel, 1);
    end
  endtask

  // Monitor: scoreboard pops, handshake stability and single-in-flight checks.
  logic prev_stall = 1'b0;
  logic [31:0] prev_a, prev_b;
  logic [2:0] prev_rm;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (res_wr_en) handleEvent(K_WR);
      if (done) handleEvent(K_DONE);
      if (aborted) handleEvent(K_ABT);
      if (prev_stall) begin
        checkOutput("in_valid held", div_in_valid, 1);
        checkOutput("div_a stable", div_a, prev_a);
        checkOutput("div_b stable", div_b, prev_b);
        checkOutput("round_mode stable", div_round_mode, prev_rm);
      end
      if (div_in_valid && m_busy) checkOutput("in_valid while divide in flight", 1, 0);
      prev_stall = div_in_valid && !div_in_ready;
      prev_a     = div_a;
      prev_b     = div_b;
      prev_rm    = div_round_mode;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " busy/done/aborted/cancel"}, {busy, done, aborted, div_cancel}, 0);
    checkOutput({tag, " strobes"}, {num_rd_en, res_wr_en, div_in_valid}, 0);
    checkOutput({tag, " exc_acc"}, exc_acc, 0);
    checkOutput({tag, " addrs"}, {num_rd_addr, res_wr_addr}, 0);
    checkOutput({tag, " div_a"}, div_a, 0);
    checkOutput({tag, " div_b"}, div_b, 0);
    checkOutput({tag, " div_round_mode"}, div_round_mode, 0);
    checkOutput({tag, " res_wr_data"}, res_wr_data, 0);
  endtask

  task automatic waitDrained(input string name, input int budget);
    int cnt = 0;
    while (exp_q.size() != 0 && cnt < budget) begin
      tick();
      cnt++;
    end
    checkOutput(name, exp_q.size(), 0);
    if (exp_q.size() != 0) begin
      exp_q.delete();
      rst = 1'b1;
      tick();
      rst = 1'b0;
    end
  endtask

  // Runs one full vector; optionally pulses a competing start while busy.
  task automatic applyStimulus(input logic [N*32-1:0] nums, input logic [31:0] d,
                               input logic [2:0] rm, input bit start_when_busy);
    ev_t e;
    logic [4:0] acc = '0;
    int x0;
    for (int i = 0; i < N; i++) begin
      num_mem[i] = nums[i*32 +: 32];
      e.kind = K_WR;
      e.addr = i;
      e.data = ref_quot(nums[i*32 +: 32], d, rm);
      e.exc  = '0;
      acc    = acc | ref_exc(nums[i*32 +: 32], d, rm);
      exp_q.push_back(e);
    end
    e.kind = K_DONE;
    e.addr = 0;
    e.data = '0;
    e.exc  = acc;
    exp_q.push_back(e);
    x0 = xfer_count;
    start      = 1'b1;
    denom      = d;
    round_mode = rm;
    tick();
    start      = 1'b0;
    denom      = $urandom;
    round_mode = 3'($urandom_range(7, 0));
    if (start_when_busy) begin
      repeat (3) tick();
      checkOutput("busy during op", busy, 1);
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    waitDrained("vector completes", 3000);
    tick();
    checkOutput("busy after done", busy, 0);
    checkOutput("divider transfers per vector", xfer_count - x0, N);
  endtask

  initial begin
    ev_t e;
    int x0;
    int cnt;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    checkAllZero("reset");
    rst = 1'b0;
    tick();

    // Exact quotients, no flags
    applyStimulus({32'h3F800000, 32'hC1400000, 32'h40C00000}, 32'h40000000, 3'd0, 1'b0);
    // Inexact 1/3 -> NX
    applyStimulus({32'h3F800000, 32'h3F800000, 32'h3F800000}, 32'h40400000, 3'd0, 1'b0);

    // Divider pulse while idle must not touch exc_acc
    inject_spur = 1'b1;
    tick();
    inject_spur = 1'b0;
    repeat (3) tick();
    checkOutput("exc_acc held after done", exc_acc, 5'b00001);

    // Divide by zero -> DZ
    applyStimulus({32'h40C00000, 32'h40C00000, 32'h40C00000}, 32'h00000000, 3'd0, 1'b0);

    // in_ready held low ~20 cycles on the first element
    hold_ready = 1'b1;
    fork
      applyStimulus({32'h3F800000, 32'hC1400000, 32'h40C00000}, 32'h40400000, 3'd0, 1'b0);
      begin
        repeat (24) tick();
        hold_ready = 1'b0;
      end
    join

    // Start while busy is ignored
    applyStimulus({32'h3F800000, 32'hC1400000, 32'h40C00000}, 32'h40000000, 3'd0, 1'b1);

    // Abort during WAIT of element 1
    lat_min = 15;
    lat_max = 15;
    num_mem[0] = 32'h40C00000;
    num_mem[1] = 32'hC1400000;
    num_mem[2] = 32'h3F800000;
    e.kind = K_WR; e.addr = 0; e.data = 32'h40400000; e.exc = '0;
    exp_q.push_back(e);
    e.kind = K_ABT; e.addr = 0; e.data = '0;
    exp_q.push_back(e);
    x0 = xfer_count;
    start = 1'b1;
    denom = 32'h40000000;
    round_mode = 3'd0;
    tick();
    start = 1'b0;
    cnt = 0;
    while (xfer_count < x0 + 2 && cnt < 500) begin
      tick();
      cnt++;
    end
    checkOutput("second element issued", xfer_count - x0, 2);
    repeat (2) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (30) tick();
    checkOutput("abort events drained", exp_q.size(), 0);
    exp_q.delete();
    checkOutput("idle after abort", busy, 0);
    checkOutput("cancel is one cycle", div_cancel, 0);
    lat_min = 1;
    lat_max = 5;

    // abort beats start in IDLE
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checkOutput("start with abort ignored", busy, 0);
    repeat (3) tick();

    // Reset in the middle of ISSUE
    hold_ready = 1'b1;
    start = 1'b1;
    denom = 32'h40000000;
    tick();
    start = 1'b0;
    cnt = 0;
    while (!div_in_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    checkOutput("reached issue", div_in_valid, 1);
    rst = 1'b1;
    #1;
    checkAllZero("mid-op reset");
    tick();
    rst = 1'b0;
    hold_ready = 1'b0;
    tick();
    checkOutput("idle after mid-op reset", busy, 0);

    // Randomized vectors
    for (int t = 0; t < 8; t++) begin
      logic [N*32-1:0] nums;
      for (int i = 0; i < N; i++) nums[i*32 +: 32] = $urandom;
      lat_max = $urandom_range(8, 1);
      applyStimulus(nums, $urandom, 3'($urandom_range(4, 0)), 1'(t % 3 == 2));
    end

    repeat (5) tick();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

endmodule
